// File: rtl/breakout_pkg.sv
// Shared Breakout definitions: key codes, screen bounds, paddle FSM states
// and the keycode-to-direction decode used by the paddle controller.
package breakout_pkg;

    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2c;

    localparam int SCREEN_X_MIN = 0;
    localparam int SCREEN_X_MAX = 639;
    localparam int SCREEN_Y_MIN = 0;
    localparam int SCREEN_Y_MAX = 479;

    typedef enum logic [0:0] {
        SERVE = 1'b0,
        PLAY  = 1'b1
    } paddle_state_t;

    // D moves right, A moves left, every other key leaves direction neutral.
    function automatic logic signed [1:0] decode_dir(input logic [7:0] key);
        logic signed [1:0] dir;
        case (key)
            KEY_D:   dir = 2'sd1;
            KEY_A:   dir = -2'sd1;
            default: dir = 2'sd0;
        endcase
        return dir;
    endfunction

endpackage

// File: rtl/paddle_vel_ramp.sv
// Velocity ramp for the paddle: a held key adds one px/frame of speed every
// ACCEL_FRAMES frames up to +/-cap, release decays speed by 1 per frame and
// a reversal stops the paddle dead. Only the frame counter is stored here;
// the velocity register lives in the top so the wall clamp can zero it.
module paddle_vel_ramp #(
    parameter int ACCEL_FRAMES = 2,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic signed [1:0] dir,
    input  logic signed [5:0] cap,
    input  logic              clear,
    input  logic signed [5:0] vel,
    output logic signed [5:0] vel_next
);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;

    // Next velocity and next hold counter from direction, cap and current speed.
    always_comb begin
        vel_next   = vel;
        cnt_next_s = cnt_r;
        if (clear) begin
            vel_next   = 6'sd0;
            cnt_next_s = '0;
        end else if (dir == 2'sd0) begin
            cnt_next_s = '0;
            if (vel > 6'sd0) begin
                vel_next = vel - 6'sd1;
            end else if (vel < 6'sd0) begin
                vel_next = vel + 6'sd1;
            end else begin
                vel_next = 6'sd0;
            end
        end else if (((dir > 2'sd0) && (vel < 6'sd0)) || ((dir < 2'sd0) && (vel > 6'sd0))) begin
            vel_next   = 6'sd0;
            cnt_next_s = '0;
        end else if (cnt_r == CNT_W'(ACCEL_FRAMES - 1)) begin
            cnt_next_s = '0;
            if (dir > 2'sd0) begin
                vel_next = (vel >= cap) ? cap : (vel + 6'sd1);
            end else begin
                vel_next = (vel <= -cap) ? -cap : (vel - 6'sd1);
            end
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Hold-frame counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

endmodule

// File: rtl/paddle.sv
// Breakout player paddle: SERVE/PLAY state machine, velocity ramp, wall
// clamp and registered position outputs, updated once per video frame.
module paddle
    import breakout_pkg::*;
#(
    parameter int BAR_X_START  = 320,
    parameter int BAR_Y_POS    = 460,
    parameter int BAR_HALF_W   = 32,
    parameter int BAR_HALF_H   = 4,
    parameter int X_MIN        = SCREEN_X_MIN,
    parameter int X_MAX        = SCREEN_X_MAX,
    parameter int V_MAX        = 8,
    parameter int ACCEL_FRAMES = 2
) (
    input  logic              frame_clk,
    input  logic              Reset_n,
    input  logic [7:0]        keycode,
    input  logic              Bar_Reset,
    output logic [9:0]        BarX,
    output logic [9:0]        BarY,
    output logic [9:0]        Bar_Sizex,
    output logic [9:0]        Bar_Sizey,
    output logic signed [5:0] Bar_Vel,
    output logic              Serving
);

    // Legal range for the paddle centre so its edges stay on screen.
    localparam logic signed [10:0] X_LO = 11'(X_MIN + BAR_HALF_W);
    localparam logic signed [10:0] X_HI = 11'(X_MAX - BAR_HALF_W);

    paddle_state_t     state_r;
    logic [9:0]        bar_x_r;
    logic signed [5:0] vel_r;
    logic              serving_r;

    logic signed [1:0]  dir_s;
    logic signed [5:0]  cap_s;
    logic signed [5:0]  vel_ramp_s;
    logic signed [5:0]  vel_next_s;
    logic signed [10:0] x_sum_s;
    logic [9:0]         x_next_s;

    // Direction from the key and the speed cap for the current state.
    always_comb begin
        dir_s = decode_dir(keycode);
        if (state_r == PLAY) begin
            cap_s = 6'(V_MAX);
        end else begin
            cap_s = 6'(V_MAX / 2);
        end
    end

    paddle_vel_ramp #(
        .ACCEL_FRAMES (ACCEL_FRAMES),
        .CNT_W        (8)
    ) u_ramp (
        .clk      (frame_clk),
        .rst_n    (Reset_n),
        .dir      (dir_s),
        .cap      (cap_s),
        .clear    (Bar_Reset),
        .vel      (vel_r),
        .vel_next (vel_ramp_s)
    );

    // Advance position by the new velocity, stopping dead against either wall.
    always_comb begin
        x_sum_s = signed'({1'b0, bar_x_r}) + 11'(vel_ramp_s);
        if (x_sum_s > X_HI) begin
            x_next_s   = 10'(X_HI);
            vel_next_s = 6'sd0;
        end else if (x_sum_s < X_LO) begin
            x_next_s   = 10'(X_LO);
            vel_next_s = 6'sd0;
        end else begin
            x_next_s   = x_sum_s[9:0];
            vel_next_s = vel_ramp_s;
        end
    end

    // Serve/play FSM with position, velocity and Serving registers; a miss
    // re-centre from the ball stage overrides everything else.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r   <= SERVE;
            bar_x_r   <= 10'(BAR_X_START);
            vel_r     <= 6'sd0;
            serving_r <= 1'b1;
        end else if (Bar_Reset) begin
            state_r   <= SERVE;
            bar_x_r   <= 10'(BAR_X_START);
            vel_r     <= 6'sd0;
            serving_r <= 1'b1;
        end else begin
            bar_x_r <= x_next_s;
            vel_r   <= vel_next_s;
            case (state_r)
                SERVE: begin
                    if (keycode == KEY_SPACE) begin
                        state_r   <= PLAY;
                        serving_r <= 1'b0;
                    end else begin
                        state_r   <= SERVE;
                        serving_r <= 1'b1;
                    end
                end
                PLAY: begin
                    state_r   <= PLAY;
                    serving_r <= 1'b0;
                end
                default: begin
                    state_r   <= SERVE;
                    serving_r <= 1'b1;
                end
            endcase
        end
    end

    assign BarX      = bar_x_r;
    assign Bar_Vel   = vel_r;
    assign Serving   = serving_r;
    assign BarY      = 10'(BAR_Y_POS);
    assign Bar_Sizex = 10'(BAR_HALF_W);
    assign Bar_Sizey = 10'(BAR_HALF_H);

endmodule

// File: tb/tb_paddle.sv
// Self-checking bench for the Breakout paddle controller.
module tb_paddle;
    import breakout_pkg::*;

    logic              frame_clk;
    logic              Reset_n;
    logic [7:0]        keycode;
    logic              Bar_Reset;
    logic [9:0]        BarX;
    logic [9:0]        BarY;
    logic [9:0]        Bar_Sizex;
    logic [9:0]        Bar_Sizey;
    logic signed [5:0] Bar_Vel;
    logic              Serving;

    paddle dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .keycode   (keycode),
        .Bar_Reset (Bar_Reset),
        .BarX      (BarX),
        .BarY      (BarY),
        .Bar_Sizex (Bar_Sizex),
        .Bar_Sizey (Bar_Sizey),
        .Bar_Vel   (Bar_Vel),
        .Serving   (Serving)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int   x;
        int   v;
        logic s;
    } exp_t;

    typedef struct {
        logic [7:0] key;
        logic       brst;
        int         x;
        int         v;
        logic       s;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[13];

    int vectors;
    int miscompares;

    // reference model state
    int m_x;
    int m_v;
    int m_c;
    bit m_play;

    function automatic void model_reset();
        m_x = 320; m_v = 0; m_c = 0; m_play = 1'b0;
    endfunction

    function automatic void model_step(input logic [7:0] key, input logic brst);
        int dir;
        int cap;
        int nx;
        if (brst) begin
            model_reset();
            return;
        end
        dir = (key == 8'h07) ? 1 : ((key == 8'h04) ? -1 : 0);
        cap = m_play ? 8 : 4;
        if (dir == 0) begin
            m_c = 0;
            if (m_v > 0) m_v = m_v - 1;
            else if (m_v < 0) m_v = m_v + 1;
        end else if ((m_v > 0 && dir < 0) || (m_v < 0 && dir > 0)) begin
            m_v = 0;
            m_c = 0;
        end else if (m_c == 1) begin
            m_c = 0;
            m_v = m_v + dir;
            if (m_v > cap) m_v = cap;
            if (m_v < -cap) m_v = -cap;
        end else begin
            m_c = m_c + 1;
        end
        nx = m_x + m_v;
        if (nx > 607) begin nx = 607; m_v = 0; end
        if (nx < 32) begin nx = 32; m_v = 0; end
        m_x = nx;
        if (!m_play && key == 8'h2c) m_play = 1'b1;
    endfunction

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Drive one frame, queue the expectation, and compare after the edge.
    task automatic drive(input string name, input logic [7:0] key, input logic brst, input exp_t e);
        exp_t got;
        @(negedge frame_clk);
        keycode   = key;
        Bar_Reset = brst;
        sb_q.push_back(e);
        @(posedge frame_clk);
        #1;
        got = sb_q.pop_front();
        vectors++;
        if (int'(BarX) != got.x || int'(Bar_Vel) != got.v || Serving !== got.s) begin
            miscompares++;
            $display("FAIL %s: got x=%0d v=%0d s=%0b, expected x=%0d v=%0d s=%0b",
                     name, BarX, Bar_Vel, Serving, got.x, got.v, got.s);
        end
    endtask

    task automatic frame(input string name, input logic [7:0] key, input logic brst);
        exp_t e;
        model_step(key, brst);
        e.x = m_x; e.v = m_v; e.s = !m_play;
        drive(name, key, brst, e);
    endtask

    initial begin
        int x0;
        int k;
        logic [7:0] rk;
        exp_t e;
        vectors = 0;
        miscompares = 0;
        Reset_n = 1'b0;
        keycode = 8'h00;
        Bar_Reset = 1'b0;
        model_reset();

        // serve ramp table: hold D from reset, then space into PLAY
        for (int i = 0; i < 12; i++) tbl[i].key = KEY_D;
        tbl[0].x = 320; tbl[1].x = 321; tbl[2].x = 322;  tbl[3].x = 324;
        tbl[4].x = 326; tbl[5].x = 329; tbl[6].x = 332;  tbl[7].x = 336;
        tbl[8].x = 340; tbl[9].x = 344; tbl[10].x = 348; tbl[11].x = 352;
        tbl[0].v = 0; tbl[1].v = 1; tbl[2].v = 1;  tbl[3].v = 2;
        tbl[4].v = 2; tbl[5].v = 3; tbl[6].v = 3;  tbl[7].v = 4;
        tbl[8].v = 4; tbl[9].v = 4; tbl[10].v = 4; tbl[11].v = 4;
        for (int i = 0; i < 12; i++) begin
            tbl[i].brst = 1'b0;
            tbl[i].s = 1'b1;
        end
        tbl[12] = '{8'h2c, 1'b0, 355, 3, 1'b0};

        repeat (2) @(negedge frame_clk);
        check("rst_x", int'(BarX), 320);
        check("rst_vel", int'(Bar_Vel), 0);
        check("rst_serving", int'(Serving), 1);
        check("bar_y", int'(BarY), 460);
        check("size_x", int'(Bar_Sizex), 32);
        check("size_y", int'(Bar_Sizey), 4);
        Reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            model_step(tbl[i].key, tbl[i].brst);
            e.x = tbl[i].x; e.v = tbl[i].v; e.s = tbl[i].s;
            drive("serve_tbl", tbl[i].key, tbl[i].brst, e);
        end

        // play ramp to full speed, then release
        for (int i = 0; i < 20; i++) frame("play_ramp", KEY_D, 1'b0);
        check("play_vmax", int'(Bar_Vel), 8);
        x0 = int'(BarX);
        for (int i = 0; i < 8; i++) frame("release", 8'h00, 1'b0);
        check("release_vel", int'(Bar_Vel), 0);
        check("release_dist", int'(BarX) - x0, 28);

        // right wall
        for (int i = 0; i < 300 && BarX != 10'd607; i++) frame("to_rwall", KEY_D, 1'b0);
        check("rwall_x", int'(BarX), 607);
        check("rwall_vel", int'(Bar_Vel), 0);
        for (int i = 0; i < 6; i++) frame("hold_rwall", KEY_D, 1'b0);
        check("rwall_hold", int'(BarX), 607);

        // left wall
        for (int i = 0; i < 300 && BarX != 10'd32; i++) frame("to_lwall", KEY_A, 1'b0);
        check("lwall_x", int'(BarX), 32);
        check("lwall_vel", int'(Bar_Vel), 0);

        // re-centre and reversal at +6
        frame("recentre", 8'h00, 1'b1);
        frame("serve_space", KEY_SPACE, 1'b0);
        for (int i = 0; i < 40 && Bar_Vel != 6'sd6; i++) frame("to_v6", KEY_D, 1'b0);
        check("rev_v6", int'(Bar_Vel), 6);
        x0 = int'(BarX);
        frame("reverse", KEY_A, 1'b0);
        check("rev_vel0", int'(Bar_Vel), 0);
        check("rev_x_hold", int'(BarX), x0);
        frame("rev_1", KEY_A, 1'b0);
        frame("rev_2", KEY_A, 1'b0);
        check("rev_vel_m1", int'(Bar_Vel), -1);

        // miss re-centre with space in the same frame
        for (int i = 0; i < 6; i++) frame("pre_miss", KEY_D, 1'b0);
        frame("miss", KEY_SPACE, 1'b1);
        check("miss_x", int'(BarX), 320);
        check("miss_vel", int'(Bar_Vel), 0);
        check("miss_serving", int'(Serving), 1);
        frame("miss_space", KEY_SPACE, 1'b0);
        check("miss_space_srv", int'(Serving), 0);

        // asynchronous reset in the middle of motion
        for (int i = 0; i < 6; i++) frame("pre_areset", KEY_D, 1'b0);
        @(negedge frame_clk);
        #2 Reset_n = 1'b0;
        #1;
        check("areset_x", int'(BarX), 320);
        check("areset_vel", int'(Bar_Vel), 0);
        check("areset_srv", int'(Serving), 1);
        model_reset();
        @(negedge frame_clk);
        keycode = 8'h00;
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) frame("post_areset", 8'h00, 1'b0);

        // random keys and occasional re-centre against the model
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 5);
            case (k)
                0: rk = 8'h00;
                1: rk = KEY_A;
                2, 5: rk = KEY_D;
                3: rk = KEY_SPACE;
                default: rk = 8'h15;
            endcase
            frame("random", rk, ($urandom_range(0, 39) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
